// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared definitions for the instruction queue.
//
// Holds the bus-width / constant macros shared by the fetch/decode interface
// and the per-cycle action encoding used by inst_queue.
//
// Macros: `InstBus, `AddrBus (bit ranges), `Enable/`Disable, `True/`False,
//         `Null (all-zero word), `IQ_SIZE_LOG (default log2 queue depth).
// Optional build macro honoured by inst_queue: IQ_BYPASS_EN.

`ifndef INST_QUEUE_DEFINES
`define INST_QUEUE_DEFINES
`define InstBus     31:0
`define AddrBus     31:0
`define Enable      1'b1
`define Disable     1'b0
`define True        1'b1
`define False       1'b0
`define Null        32'h0000_0000
`define IQ_SIZE_LOG 4
`endif

package inst_queue_pkg;

  // What the queue state does on the coming clock edge, in priority order:
  // reset beats hold (rdy low), hold beats flush, flush beats push/pop.
  typedef enum logic [1:0] {
    OpReset  = 2'd0,
    OpHold   = 2'd1,
    OpFlush  = 2'd2,
    OpUpdate = 2'd3
  } iq_op_e;

  function automatic iq_op_e iq_decode_op(input logic rst, input logic rdy, input logic clear);
    if (rst) begin
      return OpReset;
    end else if (!rdy) begin
      return OpHold;
    end else if (clear) begin
      return OpFlush;
    end
    return OpUpdate;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of fetched instruction/PC pairs between IF and ID.
//
// The oldest entry is presented to the decoder; it is popped when ID reports a
// successful dispatch. A misprediction Clear empties the queue.
//
// Parameters:
//   IQ_SIZE_LOG  log2 of the queue depth (default 4 -> 16 entries).
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rdy          global ready; low freezes all state
//   Clear        flush from the ROB
//   IF_S         fetch presents a valid instruction
//   IF_Inst      fetched instruction word
//   IF_pc        PC of IF_Inst
//   IF_Full      queue cannot accept a push this cycle
//   IQ_S         head entry valid
//   IQ_Inst      head instruction (zero when empty)
//   IQ_pc        head PC (zero when empty)
//   IQ_Success   ID accepted the head this cycle
//
// Build option: define IQ_BYPASS_EN to forward IF straight to ID when the
// queue is empty (same-cycle path). Without it, latency is at least 1 cycle.

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned IQ_SIZE_LOG = `IQ_SIZE_LOG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            Clear,
  input  logic            IF_S,
  input  logic [`InstBus] IF_Inst,
  input  logic [`AddrBus] IF_pc,
  output logic            IF_Full,
  output logic            IQ_S,
  output logic [`InstBus] IQ_Inst,
  output logic [`AddrBus] IQ_pc,
  input  logic            IQ_Success
);

  localparam int unsigned DEPTH = 1 << IQ_SIZE_LOG;

  localparam logic [IQ_SIZE_LOG-1:0] PtrOne  = {{(IQ_SIZE_LOG-1){1'b0}}, 1'b1};
  localparam logic [IQ_SIZE_LOG:0]   CntOne  = {{IQ_SIZE_LOG{1'b0}}, 1'b1};
  localparam logic [IQ_SIZE_LOG:0]   CntFull = (IQ_SIZE_LOG + 1)'(DEPTH);

  // Entry storage; contents are never reset, validity comes from count_q.
  logic [`InstBus] inst_mem [DEPTH];
  logic [`AddrBus] pc_mem   [DEPTH];

  logic [IQ_SIZE_LOG-1:0] head_q, tail_q;
  logic [IQ_SIZE_LOG:0]   count_q, count_d;

  iq_op_e op;
  logic   empty;
  logic   full;
  logic   bypass;       // IF entry shown directly to ID this cycle
  logic   bypass_take;  // ...and consumed by ID, so it is never stored
  logic   push;
  logic   pop;

  assign op    = iq_decode_op(rst, rdy, Clear);
  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

`ifdef IQ_BYPASS_EN
  // Only forward when the edge will actually act on the queue normally.
  assign bypass      = empty && IF_S && (op == OpUpdate);
  assign bypass_take = bypass && IQ_Success;
`else
  assign bypass      = `False;
  assign bypass_take = `False;
`endif

  // Full refuses a push even if a pop frees a slot on the same edge, which
  // keeps IF_Full a pure function of registered state.
  assign push = IF_S && !full && !bypass_take;
  assign pop  = IQ_Success && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    unique case (op)
      OpReset, OpFlush: begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end
      OpUpdate: begin
        if (push) tail_q <= tail_q + PtrOne;
        if (pop)  head_q <= head_q + PtrOne;
        count_q <= count_d;
      end
      default: begin
        // OpHold: everything keeps its value.
      end
    endcase
  end

  // Entry write at the tail.
  always_ff @(posedge clk) begin
    if ((op == OpUpdate) && push) begin
      inst_mem[tail_q] <= IF_Inst;
      pc_mem[tail_q]   <= IF_pc;
    end
  end

  assign IF_Full = full;

  always_comb begin
    IQ_S    = `Disable;
    IQ_Inst = `Null;
    IQ_pc   = `Null;
    if (bypass) begin
      IQ_S    = `Enable;
      IQ_Inst = IF_Inst;
      IQ_pc   = IF_pc;
    end else if (!empty) begin
      IQ_S    = `Enable;
      IQ_Inst = inst_mem[head_q];
      IQ_pc   = pc_mem[head_q];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized scoreboard bench for inst_queue.
//
// The driver keeps a plain queue of {inst, pc} entries as the reference model,
// computes the outputs the DUT must show in each cycle, and pushes them into a
// scoreboard queue. An independent monitor pops and compares at the falling
// edge. Build with IQ_BYPASS_EN defined to also exercise the bypass path.

module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, Clear, IF_S, IQ_Success;
  logic [31:0] IF_Inst, IF_pc;
  logic        IF_Full, IQ_S;
  logic [31:0] IQ_Inst, IQ_pc;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .Clear      (Clear),
    .IF_S       (IF_S),
    .IF_Inst    (IF_Inst),
    .IF_pc      (IF_pc),
    .IF_Full    (IF_Full),
    .IQ_S       (IQ_S),
    .IQ_Inst    (IQ_Inst),
    .IQ_pc      (IQ_pc),
    .IQ_Success (IQ_Success)
  );

  localparam int Depth = 16;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        s;
    logic        full;
    logic [31:0] inst;
    logic [31:0] pc;
    int          phase;
    int          cyc;
  } exp_t;

  ent_t model[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  int cyc    = 0;
  bit armed  = 1'b0;
  logic [31:0] next_pc = 32'h0;

  task automatic cmp(input string name, input exp_t e, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s phase %0d cyc %0d got %h exp %h", name, e.phase, e.cyc, got, want);
    end
  endtask

  // Monitor: one expected record per checked cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("iq_s", e, {31'b0, IQ_S}, {31'b0, e.s});
        cmp("if_full", e, {31'b0, IF_Full}, {31'b0, e.full});
        cmp("iq_pc", e, IQ_pc, e.pc);
        cmp("iq_inst", e, IQ_Inst, e.inst);
      end
    end
  end

  // One clock cycle of stimulus; acc reports whether the offered instruction
  // was taken (stored or consumed through the bypass).
  task automatic step(input bit r, input bit rd, input bit cl, input bit s,
                      input logic [31:0] inst, input logic [31:0] pc, input bit succ,
                      output bit acc);
    exp_t e;
    ent_t n;
    bit   byp, full, push, pop;
    rst = r; rdy = rd; Clear = cl; IF_S = s; IF_Inst = inst; IF_pc = pc; IQ_Success = succ;
    full = (model.size() == Depth);
    byp  = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = !r && rd && !cl && s && (model.size() == 0);
`endif
    e.s = (model.size() != 0) || byp;
    e.full = full;
    e.phase = phase;
    e.cyc = cyc;
    if (byp) begin
      e.inst = inst; e.pc = pc;
    end else if (model.size() != 0) begin
      e.inst = model[0].inst; e.pc = model[0].pc;
    end else begin
      e.inst = 32'h0; e.pc = 32'h0;
    end
    if (armed) sb.push_back(e);
    push = s && !full && !(byp && succ);
    pop  = succ && (model.size() != 0);
    acc  = 1'b0;
    if (r) begin
      model.delete();
    end else if (rd) begin
      if (cl) begin
        model.delete();
      end else begin
        if (pop) void'(model.pop_front());
        if (push) begin
          n.inst = inst; n.pc = pc;
          model.push_back(n);
        end
        acc = push || (byp && succ);
      end
    end
    if (r) armed = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Offer the next sequential PC with an instruction derived from it.
  task automatic fetch(input bit s, input bit succ);
    bit acc;
    step(1'b0, 1'b1, 1'b0, s, next_pc ^ 32'hA5A5_0000, next_pc, succ, acc);
    if (acc) next_pc += 32'd4;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * Depth && model.size() != 0; i++) fetch(1'b0, 1'b1);
  endtask

  initial begin
    bit acc;
    int p_s, p_succ;
    rst = 1'b1; rdy = 1'b1; Clear = 1'b0; IF_S = 1'b0; IQ_Success = 1'b0;
    IF_Inst = 32'h0; IF_pc = 32'h0;

    // Reset (second cycle is checked against reset values).
    phase = 1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);

    // Three pushes, no pops; then drain.
    phase = 2;
    for (int i = 0; i < 3; i++) fetch(1'b1, 1'b0);
    fetch(1'b0, 1'b0);
    drain();

    // Fill to 16, refused 17th, refused push alongside a pop, then a plain pop.
    phase = 3;
    for (int i = 0; i < Depth + 1; i++) fetch(1'b1, 1'b0);
    fetch(1'b1, 1'b1);
    fetch(1'b0, 1'b1);
    fetch(1'b0, 1'b0);
    drain();

    // Sustained push+pop across pointer wrap.
    phase = 4;
    next_pc = 32'h0;
    for (int i = 0; i < 40; i++) fetch(1'b1, 1'b1);
    drain();

    // Clear with a concurrent push and pop while holding 5 entries.
    phase = 5;
    for (int i = 0; i < 5; i++) fetch(1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFF0, 1'b1, acc);
    fetch(1'b0, 1'b0);
    fetch(1'b1, 1'b0);
    drain();

    // rdy low for 3 cycles with push and pop requested.
    phase = 6;
    for (int i = 0; i < 4; i++) fetch(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'hBAD0, 1'b1, acc);
    for (int i = 0; i < 3; i++) fetch(1'b1, 1'b1);
    drain();

`ifdef IQ_BYPASS_EN
    // Bypass: consumed the same cycle, then queue still empty.
    phase = 7;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0113, 32'h100, 1'b1, acc);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0213, 32'h104, 1'b0, acc);
    drain();
`endif

    // Random traffic with varying consumer pressure.
    for (int ph = 0; ph < 4; ph++) begin
      phase = 10 + ph;
      p_s    = (ph == 0) ? 90 : 70;
      p_succ = (ph == 0) ? 15 : (ph == 1) ? 85 : 50;
      for (int i = 0; i < 800; i++) begin
        step($urandom_range(999) < 3, $urandom_range(99) < 92, $urandom_range(99) < 2,
             $urandom_range(99) < p_s, $urandom, $urandom, $urandom_range(99) < p_succ, acc);
      end
    end

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
